raw10_stream_packer: RTL
========================

Name: raw10_stream_packer

Overview:
- Sits directly downstream of the RAW10 decoder, in the rxbyteclkhs domain.
- Accepts 64-bit four-pixel words (four 16-bit lanes, pixel1 in [15:0]). The decoder cannot be stalled, so the block buffers these words in a small FIFO.
- Presents the words as a ready/valid stream with start-of-frame (tuser) and end-of-line (tlast) markers for the frame-writer / DMA stage.
- Input words that arrive while the FIFO is full are dropped and flagged.

Parameters:
- DATA_W, 64, pixel word width; fixed at 4 x 16-bit lanes.
- ADDR_W, 4, FIFO address width; depth = 2^ADDR_W = 16 entries.
- LINE_WORDS, 480, words per line (1920 px / 4); must be >= 2.
- CNT_W, 16, width of the word-in-line counter and the optional frame counter.

Ports:
- rxbyteclkhs  in  1  byte clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- frame_active  in  1  high while the CSI frame is in progress.
- data_in  in  DATA_W  decoded four-pixel word.
- in_valid  in  1  data_in is valid this cycle (one-cycle pulses).
- last_packet_in  in  1  with in_valid, marks the final word of the frame.
- m_tdata  out  DATA_W  output pixel word.
- m_tvalid  out  1  output word available.
- m_tready  in  1  consumer accepts the word.
- m_tlast  out  1  word is the last of a line.
- m_tuser  out  1  word is the first of a frame.
- overflow  out  1  sticky; a word was dropped.
- fifo_level  out  ADDR_W+1  current occupancy, 0..2^ADDR_W.

Behaviour:
- Reset: reset_n low at a clock edge clears all state, regardless of activity in flight.
  - Pointers, fifo_level, word counter and overflow go to 0; sof_pending goes to 1.
  - m_tvalid, m_tlast, m_tuser and m_tdata read 0 while the FIFO is empty.
  - Reset mid-frame discards all buffered words.
- FIFO entry: {sof, eol, data}, DATA_W+2 bits. The FIFO is show-ahead: m_tdata/m_tlast/m_tuser come from the head entry, and m_tvalid = (fifo_level != 0).
- Push condition: in_valid & frame_active.
- Latency: a word pushed at edge N is visible on the outputs after edge N. This gives m_tvalid in cycle N+1 when the FIFO was empty.
- Pop condition: m_tvalid & m_tready. m_tdata, m_tlast and m_tuser hold stable while m_tvalid=1 and m_tready=0.
- Marker generation on each push (word counter wc counts 0..LINE_WORDS-1):
  - sof = sof_pending; sof_pending clears on the push.
  - eol = (wc == LINE_WORDS-1) | last_packet_in.
  - If eol, wc returns to 0; otherwise wc increments.
  - last_packet_in with a push also sets sof_pending=1 (the next push starts a new frame).
- frame_active low:
  - in_valid is ignored; no push occurs.
  - wc is cleared and sof_pending is set.
  - Buffered words still drain normally.
- Full: when fifo_level == 2^ADDR_W and no pop occurs in the same cycle, a push attempt is dropped.
  - overflow goes to 1 and stays set until reset.
  - wc and sof_pending update as if the word had been pushed, so line alignment is preserved downstream.
  - A dropped word carrying sof/eol loses its marker.
- Full with a simultaneous pop: the push is accepted and the level stays at 2^ADDR_W.
- Empty with a simultaneous push: no pop occurs (m_tvalid is still 0); the level becomes 1.
- Pointers wrap modulo 2^ADDR_W. fifo_level is updated as +1 / -1 / unchanged from push & pop.

Optional Feature:
- Macro: RAW10_PACKER_FRAME_CNT_EN.
- Defined: adds output frame_count [CNT_W-1:0].
  - Reset value 0.
  - Increments by 1 on each accepted pop with m_tuser=1.
  - Wraps from 2^CNT_W-1 to 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then hold m_tready=1 and drive 480 pushes with frame_active=1 and data_in = word index.
  - Expect 480 outputs in order.
  - Word 0 has m_tuser=1; word 479 has m_tlast=1; no other markers.
  - Each word appears one cycle after its push.
- Push 3 words with m_tready=0.
  - Expect fifo_level=3 and m_tvalid=1 with m_tdata stable at word 0.
  - Raise m_tready: expect 3 beats, then m_tvalid=0 and fifo_level=0.
- m_tready=0 and 18 pushes.
  - Expect fifo_level=16 and overflow=1 from the 17th push onward.
  - Draining yields words 0..15 only.
  - A 19th push, made while a pop occurs at full, is accepted.
- Push 100 words, the 100th with last_packet_in=1, then one more push.
  - Expect word 99 with m_tlast=1.
  - The next word has m_tuser=1 and wc restarts at 0 (its eol falls on push 480 of the new frame).
- Push 5 words mid-line, drop frame_active for 2 cycles while pulsing in_valid, then re-raise and push.
  - The in_valid pulses are ignored.
  - The next word has m_tuser=1 and the following eol occurs 480 words later.
- Buffer 4 words, then pulse reset_n=0 for one cycle.
  - m_tvalid=0 and fifo_level=0 on the next cycle; overflow is cleared.
  - With RAW10_PACKER_FRAME_CNT_EN defined: frame_count=0, and it reads 2 after two frames are drained.

Source files
------------

// File: rtl/raw10_stream_packer.sv
// raw10_stream_packer: buffers RAW10 four-pixel words in a 16-entry show-ahead FIFO and streams them with sof/eol markers
// Ports: rxbyteclkhs/reset_n (sync, active-low); frame_active, data_in, in_valid, last_packet_in from the decoder;
//   m_tdata/m_tvalid/m_tready/m_tlast/m_tuser output stream; overflow (sticky drop flag); fifo_level (occupancy).
// Optional: define RAW10_PACKER_FRAME_CNT_EN to add frame_count, counting popped start-of-frame words.
module raw10_stream_packer #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 4,
  parameter int LINE_WORDS = 480,
  parameter int CNT_W      = 16
) (
  input  logic              rxbyteclkhs,
  input  logic              reset_n,
  input  logic              frame_active,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  input  logic              last_packet_in,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              m_tuser,
  output logic              overflow,
`ifdef RAW10_PACKER_FRAME_CNT_EN
  output logic [CNT_W-1:0]  frame_count,
`endif
  output logic [ADDR_W:0]   fifo_level
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W+1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0] level;
  logic [CNT_W-1:0] wc;
  logic sof_pending, ovf, try_push, full, pop, push, eol;
  logic [DATA_W+1:0] head;
  always_comb begin
    head = mem[rd_ptr];
    try_push = in_valid & frame_active;
    full = level == (ADDR_W+1)'(DEPTH);
    m_tvalid = level != '0;
    pop = m_tvalid & m_tready;
    push = try_push & (~full | pop);
    eol = (wc == CNT_W'(LINE_WORDS - 1)) | last_packet_in;
    {m_tuser, m_tlast, m_tdata} = m_tvalid ? head : '0;
    fifo_level = level;
    overflow = ovf;
  end
  always_ff @(posedge rxbyteclkhs)
    if (push) mem[wr_ptr] <= {sof_pending, eol, data_in};
  always_ff @(posedge rxbyteclkhs) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      wc <= '0;
      sof_pending <= 1'b1;
      ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= (push & ~pop) ? level + 1'b1 : (pop & ~push) ? level - 1'b1 : level;
      if (try_push & ~push) ovf <= 1'b1;
      // dropped words still advance wc/sof_pending so downstream line alignment survives an overflow
      if (!frame_active) begin
        wc <= '0;
        sof_pending <= 1'b1;
      end else if (try_push) begin
        wc <= eol ? '0 : wc + 1'b1;
        sof_pending <= last_packet_in;
      end
    end
  end
`ifdef RAW10_PACKER_FRAME_CNT_EN
  always_ff @(posedge rxbyteclkhs)
    if (!reset_n) frame_count <= '0;
    else if (pop & m_tuser) frame_count <= frame_count + 1'b1;
`endif
endmodule
